pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline-stage register, the successor to the fixed-field inter-stage latches between IF/ID/EX/MEM/WB. It carries one packed control vector and one packed data vector per instruction, adds a valid bit and a valid/ready handshake in place of a bare load enable, inserts bubbles with forced-zero control on flush, and counts back-pressure cycles. An optional skid entry registers the upstream ready to break the combinational stall path.

## Interface
- CTRL_W, 8: width of the control vector (RegWrite, MemRead, Branch, Jump, ...); forced to zero whenever the entry is invalid.
- DATA_W, 128: width of the payload vector (PC, ALU result, store data, jump targets, ...).
- CNT_W, 16: width of the stall counter.
- Clk  in  1  rising-edge clock.
- Clr_n  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous kill of all held entries.
- In_Valid  in  1  upstream entry present.
- In_Ready  out  1  stage accepts an entry this cycle.
- In_Ctrl  in  CTRL_W  upstream control vector.
- In_Data  in  DATA_W  upstream payload.
- Out_Valid  out  1  entry presented downstream.
- Out_Ready  in  1  downstream accepts this cycle.
- Out_Ctrl  out  CTRL_W  control vector; all-zero when Out_Valid=0.
- Out_Data  out  DATA_W  payload; holds its last value when Out_Valid=0.
- StallCnt  out  CNT_W  saturating count of cycles with Out_Valid=1 and Out_Ready=0.

## Operation
- Push = In_Valid & In_Ready. Pop = Out_Valid & Out_Ready.
- Main entry (valid, ctrl, data) drives the Out_* ports directly from flops.
- Empty main: push loads main.
- Main full, pop and push in the same cycle: main reloads from the input (skid empty) or from skid (skid full, input then loads skid).
- Main full, no pop, push: input goes to skid (skid build only).
- Main full, pop, no push: skid moves to main if full, else main goes invalid.
- Flush: both valids cleared at the edge, ctrl flops cleared, data flops hold; In_Ready is 0 during a Flush cycle and no push occurs; Flush overrides any simultaneous push and pop.
- Out_Ctrl is the ctrl flop ANDed with valid, so a bubble never asserts a write or branch.
- StallCnt increments by 1 on each cycle with Out_Valid & !Out_Ready, saturates at all-ones, and is not cleared by Flush.
- Ordering is strictly FIFO; no entry is dropped or duplicated except by Flush.

## Timing
- Latency: 1 cycle from push to Out_Valid.
- Throughput: 1 entry/cycle while Out_Ready=1.
- Reset (Clr_n low, asynchronous): Out_Valid=0, Out_Ctrl=0, Out_Data=0, skid valid=0, StallCnt=0, In_Ready=1 (skid build) / 1 (no-skid build, from the empty main).
- Reset during a handshake: the entry is lost. The first push is possible on the first rising edge after Clr_n deasserts.
- Skid build: In_Ready = !skid_valid & !Flush. This is a flop output except for the Flush gate.
- No-skid build: In_Ready = (!Out_Valid | Out_Ready) & !Flush, which is combinational through Out_Ready.

## Configuration
- PIPE_STAGE_SKID_EN defined: a second (skid) entry is built. In_Ready has no path from Out_Ready, and full throughput is sustained under one-cycle downstream stalls with zero input loss.
- PIPE_STAGE_SKID_EN undefined: there is a single entry and no skid flops. In_Ready depends combinationally on Out_Ready. The handshake behaviour at the ports is otherwise identical.

## Test plan
- Reset, then In_Valid=1, In_Ctrl=0x5A, In_Data=0x1234 for 1 cycle with Out_Ready=1 -> next cycle Out_Valid=1, Out_Ctrl=0x5A, Out_Data=0x1234; the following cycle Out_Valid=0 and Out_Ctrl=0x00.
- Stream 8 entries (data 1..8) back-to-back with Out_Ready=1 -> Out_Data is 1..8 on consecutive cycles, and In_Ready stays 1.
- Skid build: stream data 1..4, drop Out_Ready for 1 cycle after 1 appears -> In_Ready=0 for exactly one cycle, outputs 1,1,2,3,4 in order with none lost, and StallCnt=1.
- Main and skid full, assert Flush together with In_Valid=1 (data 0x99) -> next cycle Out_Valid=0, Out_Ctrl=0, and 0x99 never appears; StallCnt is unchanged.
- Hold Out_Valid=1 and Out_Ready=0 for 2^CNT_W+5 cycles (CNT_W=4 in the bench) -> StallCnt saturates at 0xF.
- Drop Clr_n mid-stall with both entries full -> Out_Valid, Out_Ctrl, Out_Data and StallCnt are 0 immediately without waiting for a Clk edge, and In_Ready=1.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Valid/ready handshake bundle carrying one control vector and
//               one payload vector between pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_stage_reg_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128
);
    logic              Valid;
    logic              Ready;
    logic [CTRL_W-1:0] Ctrl;
    logic [DATA_W-1:0] Data;

    modport master (output Valid, output Ctrl, output Data, input  Ready);
    modport slave  (input  Valid, input  Ctrl, input  Data, output Ready);
endinterface

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : Elastic pipeline-stage register with flush-to-bubble, a
//               saturating back-pressure counter and an optional skid entry
//               (enabled by defining PIPE_STAGE_SKID_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic                Clk,
    input  logic                Clr_n,
    input  logic                Flush,
    pipe_stage_reg_if.slave     in_if,
    pipe_stage_reg_if.master    out_if,
    output logic [CNT_W-1:0]    StallCnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              main_vld_q,  main_vld_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic w_push;
    logic w_pop;
    logic w_in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_vld_q,  skid_vld_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    // Ready comes straight from the skid flop, so Out_Ready never reaches it.
    assign w_in_ready = ~skid_vld_q & ~Flush;
`else
    assign w_in_ready = (~main_vld_q | out_if.Ready) & ~Flush;
`endif

    assign w_pop  = main_vld_q & out_if.Ready;
    assign w_push = in_if.Valid & w_in_ready;

`ifdef PIPE_STAGE_SKID_EN
    always_comb begin
        main_vld_d  = main_vld_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_vld_d  = skid_vld_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (Flush) begin
            main_vld_d  = 1'b0;
            main_ctrl_d = '0;
            skid_vld_d  = 1'b0;
            skid_ctrl_d = '0;
        end else if (!main_vld_q || w_pop) begin
            if (skid_vld_q) begin
                main_vld_d  = 1'b1;
                main_ctrl_d = skid_ctrl_q;
                main_data_d = skid_data_q;
                skid_vld_d  = w_push;
                if (w_push) begin
                    skid_ctrl_d = in_if.Ctrl;
                    skid_data_d = in_if.Data;
                end
            end else begin
                main_vld_d = w_push;
                if (w_push) begin
                    main_ctrl_d = in_if.Ctrl;
                    main_data_d = in_if.Data;
                end
            end
        end else if (w_push) begin
            // Main is stalled: park the new entry behind it.
            skid_vld_d  = 1'b1;
            skid_ctrl_d = in_if.Ctrl;
            skid_data_d = in_if.Data;
        end
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            skid_vld_q  <= 1'b0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            skid_vld_q  <= skid_vld_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end
`else
    always_comb begin
        main_vld_d  = main_vld_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        if (Flush) begin
            main_vld_d  = 1'b0;
            main_ctrl_d = '0;
        end else if (!main_vld_q || w_pop) begin
            main_vld_d = w_push;
            if (w_push) begin
                main_ctrl_d = in_if.Ctrl;
                main_data_d = in_if.Data;
            end
        end
    end
`endif

    // Counter survives Flush: it measures downstream back-pressure, not content.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_vld_q && !out_if.Ready && (stall_cnt_q != C_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            main_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_if.Ready  = w_in_ready;
    assign out_if.Valid = main_vld_q;
    assign out_if.Ctrl  = main_ctrl_q & {CTRL_W{main_vld_q}};
    assign out_if.Data  = main_data_q;
    assign StallCnt     = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Scoreboard bench for pipe_stage_reg; works with or without
//               PIPE_STAGE_SKID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    localparam int CW = 8;
    localparam int DW = 128;
    localparam int NW = 4;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          Clk = 1'b0;
    logic          Clr_n;
    logic          Flush;
    logic [NW-1:0] stall_cnt;

    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) u_in  ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) u_out ();

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
        .Clk      (Clk),
        .Clr_n    (Clr_n),
        .Flush    (Flush),
        .in_if    (u_in),
        .out_if   (u_out),
        .StallCnt (stall_cnt)
    );

    always #5 Clk = ~Clk;

    ent_t exp_q[$];
    ent_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;
    int   rdy_low;
    int   item;
    logic acc;
    logic [NW-1:0] sc_saved;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Monitor: every downstream handshake must match the oldest expected entry.
    always @(negedge Clk) begin
        if (Clr_n && !Flush && u_out.Valid && u_out.Ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected actual=0x%0h required=none", u_out.Data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_ctrl", u_out.Ctrl, mon_e.c);
                chk("pop_data", u_out.Data, mon_e.d);
                pops++;
            end
        end
        if (Clr_n && !u_out.Valid) chk("bubble_ctrl", u_out.Ctrl, '0);
    end

    task automatic cyc(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl, output logic accepted);
        @(posedge Clk);
        #1;
        u_in.Valid  = v;
        u_in.Ctrl   = c;
        u_in.Data   = d;
        u_out.Ready = ordy;
        Flush       = fl;
        @(negedge Clk);
        accepted = v & u_in.Ready & ~fl;
        if (accepted) exp_q.push_back({c, d});
    endtask

    task automatic do_reset();
        Clr_n       = 1'b0;
        Flush       = 1'b0;
        u_in.Valid  = 1'b0;
        u_in.Ctrl   = '0;
        u_in.Data   = '0;
        u_out.Ready = 1'b1;
        repeat (2) @(negedge Clk);
        exp_q.delete();
        pops  = 0;
        Clr_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single transfer and reset state
        do_reset();
        chk("rst_out_valid", u_out.Valid, 0);
        chk("rst_out_ctrl",  u_out.Ctrl, 0);
        chk("rst_out_data",  u_out.Data, 0);
        chk("rst_stallcnt",  stall_cnt, 0);
        chk("rst_in_ready",  u_in.Ready, 1);
        cyc(1'b1, 8'h5A, 128'h1234, 1'b1, 1'b0, acc);
        cyc(1'b0, 8'h00, 128'h0, 1'b1, 1'b0, acc);
        chk("t1_out_valid", u_out.Valid, 1);
        chk("t1_out_ctrl",  u_out.Ctrl, 8'h5A);
        chk("t1_out_data",  u_out.Data, 128'h1234);
        cyc(1'b0, 8'h00, 128'h0, 1'b1, 1'b0, acc);
        chk("t1_bubble_valid", u_out.Valid, 0);
        chk("t1_bubble_ctrl",  u_out.Ctrl, 0);
        chk("t1_pops", pops, 1);

        // Back-to-back stream at full throughput
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, CW'(i + 8'h10), DW'(i), 1'b1, 1'b0, acc);
            chk("t2_in_ready", u_in.Ready, 1);
            if (i >= 2) chk("t2_out_valid", u_out.Valid, 1);
        end
        repeat (2) cyc(1'b0, 8'h00, 128'h0, 1'b1, 1'b0, acc);
        chk("t2_pops", pops, 8);
        chk("t2_queue_empty", exp_q.size(), 0);

        // One-cycle downstream stall while streaming
        do_reset();
        rdy_low = 0;
        item    = 1;
        for (int k = 0; k < 20 && item <= 4; k++) begin
            cyc(1'b1, CW'(item + 8'h20), DW'(item), (k != 1), 1'b0, acc);
            if (!u_in.Ready) rdy_low++;
            if (acc) item++;
        end
        chk("t3_all_sent", item, 5);
        repeat (3) cyc(1'b0, 8'h00, 128'h0, 1'b1, 1'b0, acc);
        chk("t3_ready_low_cycles", rdy_low, 1);
        chk("t3_stallcnt", stall_cnt, 1);
        chk("t3_pops", pops, 4);
        chk("t3_queue_empty", exp_q.size(), 0);

        // Flush with held entries and a simultaneous push
        do_reset();
        cyc(1'b1, 8'hA1, 128'h11, 1'b0, 1'b0, acc);
        cyc(1'b1, 8'hA2, 128'h22, 1'b0, 1'b0, acc);
        cyc(1'b1, 8'h99, 128'h99, 1'b1, 1'b1, acc);
        chk("t4_flush_in_ready", u_in.Ready, 0);
        chk("t4_cnt_pre", stall_cnt, 1);
        sc_saved = stall_cnt;
        exp_q.delete();
        cyc(1'b0, 8'h00, 128'h0, 1'b1, 1'b0, acc);
        chk("t4_out_valid", u_out.Valid, 0);
        chk("t4_out_ctrl",  u_out.Ctrl, 0);
        chk("t4_out_data_held", u_out.Data, 128'h11);
        chk("t4_cnt_unchanged", stall_cnt, sc_saved);
        repeat (3) cyc(1'b0, 8'h00, 128'h0, 1'b1, 1'b0, acc);
        chk("t4_no_pops", pops, 0);

        // Stall counter saturation
        do_reset();
        cyc(1'b1, 8'h3C, 128'h55, 1'b0, 1'b0, acc);
        for (int k = 0; k < 6; k++) cyc(1'b0, 8'h00, 128'h0, 1'b0, 1'b0, acc);
        chk("t5_cnt_mid", stall_cnt, 5);
        for (int k = 0; k < 20; k++) cyc(1'b0, 8'h00, 128'h0, 1'b0, 1'b0, acc);
        chk("t5_cnt_sat", stall_cnt, 4'hF);
        chk("t5_out_valid", u_out.Valid, 1);

        // Asynchronous reset in the middle of a stall
        cyc(1'b1, 8'h77, 128'h66, 1'b0, 1'b0, acc);
        #2;
        Clr_n = 1'b0;
        #1;
        chk("t6_out_valid", u_out.Valid, 0);
        chk("t6_out_ctrl",  u_out.Ctrl, 0);
        chk("t6_out_data",  u_out.Data, 0);
        chk("t6_stallcnt",  stall_cnt, 0);
        chk("t6_in_ready",  u_in.Ready, 1);
        exp_q.delete();
        u_in.Valid = 1'b0;
        @(negedge Clk);
        Clr_n = 1'b1;
        repeat (2) cyc(1'b0, 8'h00, 128'h0, 1'b1, 1'b0, acc);
        chk("t6_post_valid", u_out.Valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
